i2c_config_sequencer: RTL and testbench



---
 rtl/codec_cfg_pkg.sv | 38 +++
 rtl/i2c_config_sequencer_if.sv | 18 +
 rtl/codec_config_rom.sv | 19 +
 rtl/i2c_config_sequencer.sv | 147 ++++++++++++++
 tb/tb_i2c_config_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/codec_cfg_pkg.sv
// Shared types and codec configuration table
// for the I2C configuration sequencer.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_GAP,
    S_DONE,
    S_FAIL
  } state_t;

  localparam int ROM_DEPTH = 10;
  localparam logic [2:0] ACK_GOOD = 3'b111;

  // Word = {7-bit register address, 9-bit data}
  function automatic logic [15:0] rom_word(
    input int unsigned i
  );
    case (i)
      0: rom_word = {7'h0F, 9'h000}; // reset
      1: rom_word = {7'h00, 9'h017}; // left line in
      2: rom_word = {7'h01, 9'h017}; // right line in
      3: rom_word = {7'h02, 9'h079}; // headphone
      4: rom_word = {7'h04, 9'h012}; // analog path
      5: rom_word = {7'h05, 9'h000}; // digital path
      6: rom_word = {7'h06, 9'h000}; // power
      7: rom_word = {7'h07, 9'h042}; // format
      8: rom_word = {7'h08, 9'h000}; // sampling
      9: rom_word = {7'h09, 9'h001}; // active
      default: rom_word = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/i2c_config_sequencer_if.sv
// Sequencer <-> I2C register writer bundle.
// master = sequencer, slave = writer.
interface i2c_config_sequencer_if;
  logic        ignition;
  logic [15:0] mux_data;
  logic        finish_flag;
  logic [2:0]  ack;

  modport master (
    output ignition, mux_data,
    input  finish_flag, ack
  );

  modport slave (
    input  ignition, mux_data,
    output finish_flag, ack
  );
endinterface

// File: rtl/codec_config_rom.sv
// Combinational codec configuration table;
// out-of-range index reads as zero.
module codec_config_rom
  import codec_cfg_pkg::*;
#(
  parameter int IW = 4
) (
  input  logic [IW-1:0] idx_i,
  output logic [15:0]   word_o
);

  // Table lookup with zero fill past the end
  always_comb begin
    word_o = 16'h0000;
    if (32'(idx_i) < ROM_DEPTH)
      word_o = rom_word(32'(idx_i));
  end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the codec table, drives the I2C writer,
// retries NACK/timeout and reports done/fail.
module i2c_config_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int NUM_REGS       = 10,
  parameter int MAX_RETRY      = 3,
  parameter int GAP_CYCLES     = 50000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter bit AUTO_START     = 1'b1,
  localparam int IW =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int RW =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic clk,
  input  logic irstn,
  input  logic start,
  i2c_config_sequencer_if.master wr,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [IW-1:0] reg_index,
  output logic [RW-1:0] retry_cnt
);

  localparam int TW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW =
    (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_REGS - 1);
  localparam logic [RW-1:0] RTY_LAST =
    RW'(MAX_RETRY);

  state_t        state_q;
  logic          ign_q;
  logic [15:0]   mux_q;
  logic [IW-1:0] idx_q;
  logic [RW-1:0] rty_q;
  logic [TW-1:0] tmo_q;
  logic [GW-1:0] gap_q;
  logic          fin_q;
  logic          force_q;
  logic [15:0]   rom_w;
  logic          pass;

  codec_config_rom #(.IW(IW)) u_rom (
    .idx_i  (idx_q),
    .word_o (rom_w)
  );

  assign pass = (wr.ack == ACK_GOOD) && !force_q;

  // Sequencer FSM with registered writer outputs
  always_ff @(posedge clk or negedge irstn) begin
    if (!irstn) begin
      state_q <= S_IDLE;
      ign_q   <= 1'b0;
      mux_q   <= 16'h0000;
      idx_q   <= '0;
      rty_q   <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
      fin_q   <= 1'b0;
      force_q <= 1'b0;
    end else begin
      fin_q <= wr.finish_flag;
      case (state_q)
        S_IDLE: begin
          if (start || AUTO_START) begin
            idx_q   <= '0;
            rty_q   <= '0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          mux_q   <= rom_w;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          ign_q   <= 1'b1;
          tmo_q   <= '0;
          force_q <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (tmo_q != '1)
            tmo_q <= tmo_q + TW'(1);
          if (wr.finish_flag && !fin_q) begin
            ign_q   <= 1'b0;
            state_q <= S_CHECK;
          end else if (tmo_q == TMO_LAST) begin
            ign_q   <= 1'b0;
            force_q <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          gap_q <= '0;
          if (pass) begin
            if (idx_q == IDX_LAST) begin
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + IW'(1);
              rty_q   <= '0;
              state_q <= S_GAP;
            end
          end else if (rty_q == RTY_LAST) begin
            state_q <= S_FAIL;
          end else begin
            rty_q   <= rty_q + RW'(1);
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST)
            state_q <= S_LOAD;
          else
            gap_q <= gap_q + GW'(1);
        end
        S_DONE, S_FAIL: begin
          if (start) begin
            idx_q   <= '0;
            rty_q   <= '0;
            state_q <= S_LOAD;
          end
        end
      endcase
    end
  end

  assign wr.ignition = ign_q;
  assign wr.mux_data = mux_q;
  assign reg_index   = idx_q;
  assign retry_cnt   = rty_q;
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_FAIL);
  assign busy        = !(state_q inside
                         {S_IDLE, S_DONE, S_FAIL});

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: writer model,
// attempt scoreboard and hand-written corner cases.
module tb_i2c_config_sequencer;

  localparam int NR  = 4;
  localparam int GAP = 8;
  localparam int TMO = 200;
  localparam int MR  = 3;
  localparam int LAT = 50;

  localparam logic [15:0] W0 = 16'h1E00;
  localparam logic [15:0] W1 = 16'h0017;
  localparam logic [15:0] W2 = 16'h0217;
  localparam logic [15:0] W3 = 16'h0479;

  logic       clk = 1'b0;
  logic       irstn = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, error;
  logic [1:0] reg_index, retry_cnt;

  i2c_config_sequencer_if wr();

  i2c_config_sequencer #(
    .NUM_REGS       (NR),
    .MAX_RETRY      (MR),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .AUTO_START     (1'b1)
  ) dut (
    .clk       (clk),
    .irstn     (irstn),
    .start     (start),
    .wr        (wr),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .reg_index (reg_index),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tc;
    logic [15:0] word;
    logic [1:0]  idx;
    logic [1:0]  rty;
    logic [2:0]  ack;
    bit          hold;
    bit          stuck;
  } att_t;

  typedef struct {
    int         tc;
    bit         dn;
    bit         er;
    logic [1:0] idx;
    logic [1:0] rty;
  } fin_t;

  att_t tbl[$];
  fin_t ftbl[$];
  att_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   stuck_pend = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  task automatic add(input int tc,
                     input logic [15:0] w,
                     input logic [1:0] i,
                     input logic [1:0] r,
                     input logic [2:0] a,
                     input bit h, input bit s);
    att_t e;
    e.tc = tc; e.word = w; e.idx = i;
    e.rty = r; e.ack = a; e.hold = h;
    e.stuck = s;
    tbl.push_back(e);
  endtask

  task automatic addf(input int tc, input bit dn,
                      input bit er,
                      input logic [1:0] i,
                      input logic [1:0] r);
    fin_t f;
    f.tc = tc; f.dn = dn; f.er = er;
    f.idx = i; f.rty = r;
    ftbl.push_back(f);
  endtask

  task automatic load_sb(input int tc);
    sb.delete();
    foreach (tbl[i])
      if (tbl[i].tc == tc) sb.push_back(tbl[i]);
    stuck_pend = sb[0].stuck;
    wr.finish_flag = stuck_pend;
  endtask

  task automatic fin_chk(input int tc);
    foreach (ftbl[i]) begin
      if (ftbl[i].tc == tc) begin
        chk($sformatf("done_tc%0d", tc),
            done, ftbl[i].dn);
        chk($sformatf("error_tc%0d", tc),
            error, ftbl[i].er);
        chk($sformatf("busy_tc%0d", tc), busy, 0);
        chk($sformatf("idx_tc%0d", tc),
            reg_index, ftbl[i].idx);
        chk($sformatf("rty_tc%0d", tc),
            retry_cnt, ftbl[i].rty);
      end
    end
  endtask

  task automatic do_reset();
    irstn = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    irstn = 1'b1;
  endtask

  // Writer model + scoreboard, one step per negedge
  task automatic run(input int poke,
                     input int exp_lat,
                     input int budget);
    bit   pig = 0;
    bit   hav = 0;
    logic ig;
    int   hi = 0, lo = 0, cyc = 0;
    int   frise = -1, npulse = 0;
    int   nexp = sb.size();
    att_t cur = '{default: 0};
    forever begin
      @(negedge clk);
      ig = wr.ignition;
      if (ig && !pig) begin
        if (frise < 0) frise = cyc;
        if (hav) chk("gap_len", lo, GAP + 3);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          chk("mux_data", wr.mux_data, cur.word);
          chk("reg_index", reg_index, cur.idx);
          chk("retry_cnt", retry_cnt, cur.rty);
        end
        wr.ack = cur.ack;
        hi = 1;
        npulse++;
      end else if (ig) begin
        hi++;
      end
      if (!ig && pig) begin
        chk(cur.hold ? "tmo_width" : "ign_width",
            hi, cur.hold ? TMO : LAT);
        lo = 1;
        hav = 1;
        if (cur.stuck) stuck_pend = 1'b0;
      end else if (!ig) begin
        lo++;
      end
      if (ig && hi == LAT && !cur.hold)
        wr.finish_flag = 1'b1;
      if (!ig && !stuck_pend)
        wr.finish_flag = 1'b0;
      start = (cyc == poke);
      pig = ig;
      cyc++;
      if (sb.size() == 0 && (done || error) && !ig)
        break;
      if (cyc > budget) begin
        n_chk++;
        $display("FAIL run_budget: %0d cycles", cyc);
        break;
      end
    end
    start = 1'b0;
    if (exp_lat >= 0)
      chk("start_lat", frise - poke, exp_lat);
    chk("pulses", npulse, nexp);
  endtask

  initial begin
    // Attempt table: tc, word, idx, rty, ack, hold, stuck
    add(0, W0, 0, 0, 3'b111, 0, 0);
    add(0, W1, 1, 0, 3'b111, 0, 0);
    add(0, W2, 2, 0, 3'b111, 0, 0);
    add(0, W3, 3, 0, 3'b111, 0, 0);
    add(1, W0, 0, 0, 3'b111, 0, 0);
    add(1, W1, 1, 0, 3'b111, 0, 0);
    add(1, W2, 2, 0, 3'b101, 0, 0);
    add(1, W2, 2, 1, 3'b111, 0, 0);
    add(1, W3, 3, 0, 3'b111, 0, 0);
    add(2, W0, 0, 0, 3'b111, 0, 0);
    add(2, W1, 1, 0, 3'b101, 0, 0);
    add(2, W1, 1, 1, 3'b011, 0, 0);
    add(2, W1, 1, 2, 3'b110, 0, 0);
    add(2, W1, 1, 3, 3'b000, 0, 0);
    add(3, W0, 0, 0, 3'b111, 1, 1);
    add(3, W0, 0, 1, 3'b111, 1, 0);
    add(3, W0, 0, 2, 3'b111, 0, 0);
    add(3, W1, 1, 0, 3'b111, 0, 0);
    add(3, W2, 2, 0, 3'b111, 0, 0);
    add(3, W3, 3, 0, 3'b111, 0, 0);
    addf(0, 1, 0, 3, 0);
    addf(1, 1, 0, 3, 0);
    addf(2, 0, 1, 1, 3);
    addf(3, 1, 0, 3, 0);

    wr.finish_flag = 1'b0;
    wr.ack = 3'b000;
    #12;
    chk("rst_ignition", wr.ignition, 0);
    chk("rst_mux_data", wr.mux_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_reg_index", reg_index, 0);
    chk("rst_retry_cnt", retry_cnt, 0);

    for (int tc = 0; tc < 4; tc++) begin
      irstn = 1'b0;
      load_sb(tc);
      do_reset();
      run(tc == 0 ? 100 : -1, -1, 3000);
      fin_chk(tc);
    end

    // Second run started from DONE
    load_sb(0);
    run(2, 3, 3000);
    fin_chk(0);

    // Reset while waiting on the writer
    irstn = 1'b0;
    wr.finish_flag = 1'b0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wr.ignition) break;
    end
    chk("ign_before_rst", wr.ignition, 1);
    repeat (5) @(negedge clk);
    chk("busy_before_rst", busy, 1);
    chk("mux_before_rst", wr.mux_data, W0);
    #2 irstn = 1'b0;
    #1;
    chk("async_rst_ignition", wr.ignition, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_mux", wr.mux_data, 0);
    load_sb(0);
    @(negedge clk);
    irstn = 1'b1;
    run(-1, -1, 3000);
    fin_chk(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
